// File: rtl/uart_alu_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_pkg
// Shared definitions for the UART <-> ALU sequencer:
//   - state_t            : 3-bit FSM state encoding of the sequencer
//   - OP_*               : ALU opcodes, shared with the ALU itself
//   - DEFAULT_DATA_WIDTH : default operand / result / UART byte width
// -----------------------------------------------------------------------------
package uart_alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // ALU opcodes; OP_RESET is what the opcode register holds out of reset
    localparam logic [7:0] OP_ADD   = 8'h20;
    localparam logic [7:0] OP_SUB   = 8'h22;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_RESET = 8'h00;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/byte_timeout_timer.sv
// -----------------------------------------------------------------------------
// byte_timeout_timer
// Inter-byte timeout counter for the UART <-> ALU sequencer. Only compiled
// when UART_ALU_IF_TIMEOUT_EN is defined, which is also the only build that
// instantiates it.
// Ports:
//   clk     in  : system clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   clear   in  : synchronous clear to 0 (has priority over enable)
//   enable  in  : count one step per cycle
//   expire  out : count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
`ifdef UART_ALU_IF_TIMEOUT_EN
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Counter saturates at LAST so expire stays asserted until the next clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule
`endif

// File: rtl/uart_alu_interface.sv
// -----------------------------------------------------------------------------
// uart_alu_interface
// Sequencer between the UART receiver, a combinational ALU and the UART
// transmitter. Collects operand A, operand B and opcode bytes, presents them
// as registered operands, captures the ALU result and starts a transmission,
// then waits for the transmitter before accepting the next frame.
// Optional feature macro: UART_ALU_IF_TIMEOUT_EN (inter-byte timeout that
// discards a partial frame; without it o_timeout is tied low).
// Ports:
//   i_clk, i_rst_n   : clock (rising edge), asynchronous active-low reset
//   i_rx_data        : received byte, valid while i_rx_done = 1
//   i_rx_done        : one-cycle pulse, byte received
//   o_dato_a/o_dato_b: registered operands to the ALU
//   o_op_code        : registered opcode to the ALU (low bits of the byte)
//   i_alu_result     : combinational ALU result
//   o_tx_data        : registered byte to transmit
//   o_tx_start       : one-cycle pulse, start transmission
//   i_tx_done        : one-cycle pulse, transmitter finished
//   o_timeout        : one-cycle pulse, partial frame discarded
// -----------------------------------------------------------------------------
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int OP_CODE_SIZE   = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_WIDTH-1:0]   i_rx_data,
    input  logic                    i_rx_done,
    output logic [DATA_WIDTH-1:0]   o_dato_a,
    output logic [DATA_WIDTH-1:0]   o_dato_b,
    output logic [OP_CODE_SIZE-1:0] o_op_code,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_done,
    output logic                    o_timeout
);

    // Elaboration-time parameter sanity checks
    if (OP_CODE_SIZE > DATA_WIDTH) begin : g_bad_op_width
        $error("OP_CODE_SIZE must not exceed DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t state;
    state_t state_next;
    logic   timeout_hit;

`ifdef UART_ALU_IF_TIMEOUT_EN
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expire;

    // Counter runs while a frame is partially received; entering WAIT_B and
    // every accepted byte restart it. A byte in the expiry cycle wins.
    assign tmr_enable  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    assign tmr_clear   = i_rx_done && ((state == ST_WAIT_A) || tmr_enable);
    assign timeout_hit = tmr_enable && tmr_expire && !i_rx_done;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (tmr_clear),
        .enable(tmr_enable),
        .expire(tmr_expire)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; bytes outside the three receive states are dropped
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT_A:  if (i_rx_done) state_next = ST_WAIT_B;
            ST_WAIT_B:  begin
                if (i_rx_done)        state_next = ST_WAIT_OP;
                else if (timeout_hit) state_next = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (i_rx_done)        state_next = ST_EXEC;
                else if (timeout_hit) state_next = ST_WAIT_A;
            end
            ST_EXEC:    state_next = ST_SEND;
            ST_SEND:    state_next = ST_WAIT_TX;
            ST_WAIT_TX: if (i_tx_done) state_next = ST_WAIT_A;
            default:    state_next = ST_WAIT_A;
        endcase
    end

    // Operand/opcode/result registers; they hold across frames and are only
    // overwritten by the next frame's bytes or the next EXEC capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dato_a  <= '0;
            o_dato_b  <= '0;
            o_op_code <= '0;
            o_tx_data <= '0;
        end else begin
            if ((state == ST_WAIT_A) && i_rx_done) o_dato_a <= i_rx_data;
            if ((state == ST_WAIT_B) && i_rx_done) o_dato_b <= i_rx_data;
            if ((state == ST_WAIT_OP) && i_rx_done) o_op_code <= i_rx_data[OP_CODE_SIZE-1:0];
            if (state == ST_EXEC) o_tx_data <= i_alu_result;
        end
    end

    assign o_tx_start = (state == ST_SEND);
    assign o_timeout  = timeout_hit;

endmodule

// File: tb/tb_uart_alu_interface.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_interface
// Directed self-checking bench for uart_alu_interface with a behavioural ALU
// attached. Define UART_ALU_IF_TIMEOUT_EN to exercise the timeout feature
// (TIMEOUT_CYCLES = 16 here).
// -----------------------------------------------------------------------------
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] dato_a;
    logic [7:0] dato_b;
    logic [7:0] op_code;
    logic [7:0] alu_result;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       timeout;

    int checks         = 0;
    int errors         = 0;
    int startPulses    = 0;
    int timeoutPulses  = 0;
    int expectedStarts = 0;
    int expectedTimeouts;

    uart_alu_interface #(
        .DATA_WIDTH    (8),
        .OP_CODE_SIZE  (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .o_dato_a    (dato_a),
        .o_dato_b    (dato_b),
        .o_op_code   (op_code),
        .i_alu_result(alu_result),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_done   (tx_done),
        .o_timeout   (timeout)
    );

    // Clock: 10 ns period
    always #5 clk = ~clk;

    // Behavioural ALU driven by the registered operands
    always_comb begin
        alu_result = 8'h00;
        case (op_code)
            8'h20:   alu_result = dato_a + dato_b;
            8'h22:   alu_result = dato_a - dato_b;
            8'h24:   alu_result = dato_a & dato_b;
            8'h25:   alu_result = dato_a | dato_b;
            8'h26:   alu_result = dato_a ^ dato_b;
            8'h03:   alu_result = 8'($signed(dato_a) >>> dato_b);
            8'h02:   alu_result = dato_a >> dato_b;
            8'h27:   alu_result = ~(dato_a | dato_b);
            default: alu_result = 8'h00;
        endcase
    end

    // Pulse monitor, sampled mid-cycle away from both clock edges
    always @(posedge clk) begin
        #2;
        if (tx_start === 1'b1) startPulses++;
        if (timeout === 1'b1) timeoutPulses++;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one received byte for one cycle; returns one negedge after capture
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulseTxDone();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Full frame: check registered operands, EXEC gap, start pulse and result
    task automatic runFrame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(op);
        checkOutput("dato_a", dato_a, a);
        checkOutput("dato_b", dato_b, b);
        checkOutput("op_code", op_code, op);
        checkOutput("exec_no_start", tx_start, 1'b0);
        @(negedge clk);
        checkOutput("send_start", tx_start, 1'b1);
        checkOutput("tx_data", tx_data, exp);
        expectedStarts++;
        @(negedge clk);
        checkOutput("start_one_cycle", tx_start, 1'b0);
        checkOutput("tx_data_held", tx_data, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_dato_a", dato_a, 8'h00);
        checkOutput("rst_dato_b", dato_b, 8'h00);
        checkOutput("rst_op_code", op_code, 8'h00);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_tx_start", tx_start, 1'b0);
        checkOutput("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;

        $display("[TB] basic frames");
        runFrame(8'h05, 8'h03, 8'h20, 8'h08);
        pulseTxDone();
        runFrame(8'h03, 8'h05, 8'h22, 8'hFE);
        pulseTxDone();

        $display("[TB] back-to-back frames");
        runFrame(8'hF0, 8'h0F, 8'h27, 8'h00);
        pulseTxDone();
        runFrame(8'hFF, 8'h3C, 8'h24, 8'h3C);

        $display("[TB] dropped bytes");
        applyStimulus(8'hAA);
        checkOutput("waittx_drop_a", dato_a, 8'hFF);
        checkOutput("waittx_drop_b", dato_b, 8'h3C);
        checkOutput("waittx_drop_op", op_code, 8'h24);
        checkOutput("waittx_drop_tx", tx_data, 8'h3C);
        @(negedge clk);
        rx_data = 8'h77;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        checkOutput("coincident_drop_a", dato_a, 8'hFF);
        pulseTxDone();
        checkOutput("stray_txdone_no_start", tx_start, 1'b0);
        runFrame(8'h01, 8'h01, 8'h20, 8'h02);
        pulseTxDone();
        runFrame(8'h81, 8'h02, 8'h03, 8'hE0);
        pulseTxDone();

        $display("[TB] reset mid-frame");
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        checkOutput("pre_rst_dato_b", dato_b, 8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dato_a", dato_a, 8'h00);
        checkOutput("midrst_dato_b", dato_b, 8'h00);
        checkOutput("midrst_op_code", op_code, 8'h00);
        checkOutput("midrst_tx_data", tx_data, 8'h00);
        checkOutput("midrst_tx_start", tx_start, 1'b0);
        checkOutput("midrst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        runFrame(8'h09, 8'h04, 8'h25, 8'h0D);
        pulseTxDone();

`ifdef UART_ALU_IF_TIMEOUT_EN
        $display("[TB] timeout expiry");
        expectedTimeouts = 1;
        applyStimulus(8'h44);
        repeat (14) @(negedge clk);
        checkOutput("timeout_early", timeout, 1'b0);
        @(negedge clk);
        checkOutput("timeout_expire", timeout, 1'b1);
        @(negedge clk);
        checkOutput("timeout_one_cycle", timeout, 1'b0);
        checkOutput("timeout_no_start", tx_start, 1'b0);
        checkOutput("timeout_keeps_a", dato_a, 8'h44);
        runFrame(8'h05, 8'h06, 8'h20, 8'h0B);
        pulseTxDone();

        $display("[TB] byte in expiry cycle");
        applyStimulus(8'h10);
        repeat (15) @(negedge clk);
        rx_data = 8'h20;
        rx_done = 1'b1;
        #1;
        checkOutput("expiry_rx_wins", timeout, 1'b0);
        @(negedge clk);
        rx_done = 1'b0;
        checkOutput("expiry_dato_b", dato_b, 8'h20);
        applyStimulus(8'h20);
        checkOutput("expiry_dato_a", dato_a, 8'h10);
        checkOutput("expiry_op_code", op_code, 8'h20);
        @(negedge clk);
        checkOutput("expiry_start", tx_start, 1'b1);
        checkOutput("expiry_tx_data", tx_data, 8'h30);
        expectedStarts++;
        @(negedge clk);
        pulseTxDone();
`else
        $display("[TB] partial frame waits");
        expectedTimeouts = 0;
        applyStimulus(8'h44);
        repeat (40) @(negedge clk);
        checkOutput("no_timeout", timeout, 1'b0);
        applyStimulus(8'h02);
        applyStimulus(8'h26);
        checkOutput("late_dato_a", dato_a, 8'h44);
        checkOutput("late_dato_b", dato_b, 8'h02);
        @(negedge clk);
        checkOutput("late_start", tx_start, 1'b1);
        checkOutput("late_tx_data", tx_data, 8'h46);
        expectedStarts++;
        @(negedge clk);
        pulseTxDone();
`endif

        repeat (2) @(negedge clk);
        checkOutput("start_pulse_count", startPulses, expectedStarts);
        checkOutput("timeout_pulse_count", timeoutPulses, expectedTimeouts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
